// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: default widths, ALU opcodes,
// forward-select encoding and the registered control bundle.
package id_ex_stage_pkg;

    localparam int DATA_W  = 32;
    localparam int RADDR_W = 5;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b1100;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       memto_reg;
        logic       branch;
        logic       alu_src;
        logic [3:0] alu_control;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_forward_select.sv
// Picks the forwarding source for one ALU operand; EX/MEM beats MEM/WB and x0 never forwards.
module forward_select
    import id_ex_stage_pkg::*;
#(
    parameter int RADDR_W = id_ex_stage_pkg::RADDR_W
) (
    input  logic [RADDR_W-1:0] src_i,
    input  logic               ex_mem_reg_write_i,
    input  logic [RADDR_W-1:0] ex_mem_rd_i,
    input  logic               mem_wb_reg_write_i,
    input  logic [RADDR_W-1:0] mem_wb_rd_i,
    output fwd_sel_e           sel_o
);

    always_comb begin
        sel_o = FWD_REG;
        if (ex_mem_reg_write_i && (ex_mem_rd_i != '0) && (ex_mem_rd_i == src_i)) begin
            sel_o = FWD_MEM;
        end else if (mem_wb_reg_write_i && (mem_wb_rd_i != '0) && (mem_wb_rd_i == src_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush/bubble control, operand forwarding
// into the ALU inputs, and load-use hazard detection for the decode stage.
module id_ex_stage #(
    parameter int DATA_W  = id_ex_stage_pkg::DATA_W,
    parameter int RADDR_W = id_ex_stage_pkg::RADDR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               IdValid,
    input  logic [DATA_W-1:0]  IdRegData1,
    input  logic [DATA_W-1:0]  IdRegData2,
    input  logic [DATA_W-1:0]  IdImm,
    input  logic [RADDR_W-1:0] IdRs1,
    input  logic [RADDR_W-1:0] IdRs2,
    input  logic [RADDR_W-1:0] IdRd,
    input  logic [3:0]         IdALUControl,
    input  logic               IdALUSrc,
    input  logic               IdRegWrite,
    input  logic               IdMemRead,
    input  logic               IdMemWrite,
    input  logic               IdMemtoReg,
    input  logic               IdBranch,
    input  logic               Stall,
    input  logic               Flush,
    input  logic               ExMemRegWrite,
    input  logic [RADDR_W-1:0] ExMemRd,
    input  logic [DATA_W-1:0]  ExMemALUResult,
    input  logic               MemWbRegWrite,
    input  logic [RADDR_W-1:0] MemWbRd,
    input  logic [DATA_W-1:0]  MemWbData,
    output logic [DATA_W-1:0]  Mux1Out,
    output logic [DATA_W-1:0]  Mux2Out,
    output logic [3:0]         ALUControl,
    output logic [DATA_W-1:0]  StoreData,
    output logic [RADDR_W-1:0] ExRd,
    output logic               ExRegWrite,
    output logic               ExMemRead,
    output logic               ExMemWrite,
    output logic               ExMemtoReg,
    output logic               ExBranch,
    output logic               ExValid,
    output logic               LoadUseHazard
);

    import id_ex_stage_pkg::*;

    ctrl_t              ctrl_q, ctrl_d;
    logic [DATA_W-1:0]  data1_q, data1_d, data2_q, data2_d, imm_q, imm_d;
    logic [RADDR_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    fwd_sel_e           sel_a, sel_b;
    logic [DATA_W-1:0]  fwd_b;

    always_comb begin
        // NOTE: every next-state gets a default (hold) first, so no path can infer a latch.
        ctrl_d  = ctrl_q;
        data1_d = data1_q;
        data2_d = data2_q;
        imm_d   = imm_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        // Flush outranks Stall; an invalid decode slot becomes a bubble.
        if (Flush || (!Stall && !IdValid)) begin
            ctrl_d  = CTRL_BUBBLE;
            data1_d = '0;
            data2_d = '0;
            imm_d   = '0;
            rs1_d   = '0;
            rs2_d   = '0;
            rd_d    = '0;
        end else if (!Stall) begin
            ctrl_d = '{valid:       1'b1,
                       reg_write:   IdRegWrite,
                       mem_read:    IdMemRead,
                       mem_write:   IdMemWrite,
                       memto_reg:   IdMemtoReg,
                       branch:      IdBranch,
                       alu_src:     IdALUSrc,
                       alu_control: IdALUControl};
            data1_d = IdRegData1;
            data2_d = IdRegData2;
            imm_d   = IdImm;
            rs1_d   = IdRs1;
            rs2_d   = IdRs2;
            rd_d    = IdRd;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking here would race readers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q  <= CTRL_BUBBLE;
            data1_q <= '0;
            data2_q <= '0;
            imm_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
            imm_q   <= imm_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
        end
    end

    forward_select #(.RADDR_W(RADDR_W)) u_fwd_a (
        .src_i              (rs1_q),
        .ex_mem_reg_write_i (ExMemRegWrite),
        .ex_mem_rd_i        (ExMemRd),
        .mem_wb_reg_write_i (MemWbRegWrite),
        .mem_wb_rd_i        (MemWbRd),
        .sel_o              (sel_a)
    );

    forward_select #(.RADDR_W(RADDR_W)) u_fwd_b (
        .src_i              (rs2_q),
        .ex_mem_reg_write_i (ExMemRegWrite),
        .ex_mem_rd_i        (ExMemRd),
        .mem_wb_reg_write_i (MemWbRegWrite),
        .mem_wb_rd_i        (MemWbRd),
        .sel_o              (sel_b)
    );

    always_comb begin
        Mux1Out = data1_q;
        fwd_b   = data2_q;
        case (sel_a)
            FWD_MEM: Mux1Out = ExMemALUResult;
            FWD_WB:  Mux1Out = MemWbData;
            default: Mux1Out = data1_q;
        endcase
        case (sel_b)
            FWD_MEM: fwd_b = ExMemALUResult;
            FWD_WB:  fwd_b = MemWbData;
            default: fwd_b = data2_q;
        endcase
    end

    assign Mux2Out    = ctrl_q.alu_src ? imm_q : fwd_b;
    assign StoreData  = fwd_b;
    assign ALUControl = ctrl_q.alu_control;
    assign ExRd       = rd_q;
    assign ExRegWrite = ctrl_q.reg_write;
    assign ExMemRead  = ctrl_q.mem_read;
    assign ExMemWrite = ctrl_q.mem_write;
    assign ExMemtoReg = ctrl_q.memto_reg;
    assign ExBranch   = ctrl_q.branch;
    assign ExValid    = ctrl_q.valid;

    assign LoadUseHazard = ctrl_q.valid && ctrl_q.mem_read && (rd_q != '0)
                           && ((rd_q == IdRs1) || (rd_q == IdRs2)) && IdValid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        IdValid;
    logic [31:0] IdRegData1, IdRegData2, IdImm;
    logic [4:0]  IdRs1, IdRs2, IdRd;
    logic [3:0]  IdALUControl;
    logic        IdALUSrc, IdRegWrite, IdMemRead, IdMemWrite, IdMemtoReg, IdBranch;
    logic        Stall, Flush;
    logic        ExMemRegWrite;
    logic [4:0]  ExMemRd;
    logic [31:0] ExMemALUResult;
    logic        MemWbRegWrite;
    logic [4:0]  MemWbRd;
    logic [31:0] MemWbData;
    logic [31:0] Mux1Out, Mux2Out, StoreData;
    logic [3:0]  ALUControl;
    logic [4:0]  ExRd;
    logic        ExRegWrite, ExMemRead, ExMemWrite, ExMemtoReg, ExBranch, ExValid;
    logic        LoadUseHazard;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .IdValid(IdValid),
        .IdRegData1(IdRegData1), .IdRegData2(IdRegData2), .IdImm(IdImm),
        .IdRs1(IdRs1), .IdRs2(IdRs2), .IdRd(IdRd),
        .IdALUControl(IdALUControl), .IdALUSrc(IdALUSrc),
        .IdRegWrite(IdRegWrite), .IdMemRead(IdMemRead), .IdMemWrite(IdMemWrite),
        .IdMemtoReg(IdMemtoReg), .IdBranch(IdBranch),
        .Stall(Stall), .Flush(Flush),
        .ExMemRegWrite(ExMemRegWrite), .ExMemRd(ExMemRd), .ExMemALUResult(ExMemALUResult),
        .MemWbRegWrite(MemWbRegWrite), .MemWbRd(MemWbRd), .MemWbData(MemWbData),
        .Mux1Out(Mux1Out), .Mux2Out(Mux2Out), .ALUControl(ALUControl), .StoreData(StoreData),
        .ExRd(ExRd), .ExRegWrite(ExRegWrite), .ExMemRead(ExMemRead), .ExMemWrite(ExMemWrite),
        .ExMemtoReg(ExMemtoReg), .ExBranch(ExBranch), .ExValid(ExValid),
        .LoadUseHazard(LoadUseHazard)
    );

    always #5 clk = ~clk;

    // ctrl = {valid, reg_write, mem_read, mem_write, memto_reg, branch}
    typedef struct {
        string       name;
        logic [31:0] m1, m2, sd;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic [5:0]  ctrl;
        logic        haz;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic push(input string name, input logic [31:0] m1, input logic [31:0] m2,
                        input logic [31:0] sd, input logic [3:0] alu, input logic [4:0] rd,
                        input logic [5:0] ctrl, input logic haz);
        exp_t e;
        e.name = name; e.m1 = m1; e.m2 = m2; e.sd = sd;
        e.alu = alu; e.rd = rd; e.ctrl = ctrl; e.haz = haz;
        q.push_back(e);
    endtask

    task automatic check(input exp_t e);
        logic [5:0] act_ctrl;
        act_ctrl = {ExValid, ExRegWrite, ExMemRead, ExMemWrite, ExMemtoReg, ExBranch};
        total++;
        if (Mux1Out !== e.m1 || Mux2Out !== e.m2 || StoreData !== e.sd || ALUControl !== e.alu
            || ExRd !== e.rd || act_ctrl !== e.ctrl || LoadUseHazard !== e.haz) begin
            bad++;
            $display("FAIL %s: got m1=%h m2=%h sd=%h alu=%h rd=%0d ctrl=%b haz=%b, want m1=%h m2=%h sd=%h alu=%h rd=%0d ctrl=%b haz=%b",
                     e.name, Mux1Out, Mux2Out, StoreData, ALUControl, ExRd, act_ctrl, LoadUseHazard,
                     e.m1, e.m2, e.sd, e.alu, e.rd, e.ctrl, e.haz);
        end
    endtask

    // Monitor: whenever expectations are pending, compare at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0) check(q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_id();
        IdValid = 0; IdRegData1 = '0; IdRegData2 = '0; IdImm = '0;
        IdRs1 = '0; IdRs2 = '0; IdRd = '0; IdALUControl = '0; IdALUSrc = 0;
        IdRegWrite = 0; IdMemRead = 0; IdMemWrite = 0; IdMemtoReg = 0; IdBranch = 0;
    endtask

    task automatic clear_fwd();
        ExMemRegWrite = 0; ExMemRd = '0; ExMemALUResult = '0;
        MemWbRegWrite = 0; MemWbRd = '0; MemWbData = '0;
    endtask

    initial begin
        // Reset with garbage everywhere.
        reset = 1; Stall = 1; Flush = 0;
        IdValid = 1; IdRegData1 = 32'hDEADBEEF; IdRegData2 = 32'hCAFEF00D; IdImm = 32'h12345678;
        IdRs1 = 5'd7; IdRs2 = 5'd7; IdRd = 5'd7; IdALUControl = 4'b1111; IdALUSrc = 1;
        IdRegWrite = 1; IdMemRead = 1; IdMemWrite = 1; IdMemtoReg = 1; IdBranch = 1;
        ExMemRegWrite = 1; ExMemRd = 5'd3; ExMemALUResult = 32'h99999999;
        MemWbRegWrite = 1; MemWbRd = 5'd9; MemWbData = 32'h77777777;
        step();
        push("reset", 0, 0, 0, 4'h0, 0, 6'b000000, 0);

        step();
        reset = 0; Stall = 0; clear_fwd(); clear_id();
        IdValid = 1; IdRegData1 = 32'd5; IdRegData2 = 32'd3; IdALUControl = 4'b0110;
        IdRs1 = 5'd1; IdRs2 = 5'd2; IdRd = 5'd3; IdRegWrite = 1;
        push("idle_after_reset", 0, 0, 0, 4'h0, 0, 6'b000000, 0);

        step();
        clear_id();
        IdValid = 1; IdRs1 = 5'd4; IdRs2 = 5'd5; IdRd = 5'd6;
        IdRegData1 = 32'h1; IdRegData2 = 32'h2; IdALUControl = 4'b0000; IdRegWrite = 1;
        push("plain_capture", 32'd5, 32'd3, 32'd3, 4'b0110, 5'd3, 6'b110000, 0);

        step();
        Stall = 1;
        ExMemRegWrite = 1; ExMemRd = 5'd4; ExMemALUResult = 32'hAA;
        MemWbRegWrite = 1; MemWbRd = 5'd4; MemWbData = 32'hBB;
        push("fwd_exmem_wins", 32'hAA, 32'h2, 32'h2, 4'h0, 5'd6, 6'b110000, 0);

        step();
        ExMemRegWrite = 0;
        push("fwd_memwb", 32'hBB, 32'h2, 32'h2, 4'h0, 5'd6, 6'b110000, 0);

        step();
        clear_fwd();
        push("stall_hold_2", 32'h1, 32'h2, 32'h2, 4'h0, 5'd6, 6'b110000, 0);
        Stall = 0; clear_id();
        IdValid = 1; IdRs1 = 5'd0; IdRegData1 = 32'h55; IdRs2 = 5'd8; IdRegData2 = 32'h66;
        IdImm = 32'hFFFFFFF0; IdALUSrc = 1; IdALUControl = 4'b0001; IdRd = 5'd9; IdMemWrite = 1;

        step();
        ExMemRegWrite = 1; ExMemRd = 5'd0; ExMemALUResult = 32'hAA;
        MemWbRegWrite = 1; MemWbRd = 5'd8; MemWbData = 32'h11;
        clear_id();
        IdValid = 1; IdRs1 = 5'd2; IdRs2 = 5'd3; IdRd = 5'd7; IdRegData1 = 32'h100;
        IdRegData2 = 32'h200; IdImm = 32'h4; IdALUSrc = 1; IdALUControl = 4'b0000;
        IdRegWrite = 1; IdMemRead = 1; IdMemtoReg = 1;
        push("x0_and_imm", 32'h55, 32'hFFFFFFF0, 32'h11, 4'b0001, 5'd9, 6'b100100, 0);

        step();
        clear_fwd(); clear_id();
        IdValid = 1; IdRs1 = 5'd1; IdRs2 = 5'd7; IdRd = 5'd10;
        IdRegData1 = 32'h10; IdRegData2 = 32'h20; IdALUControl = 4'b0010; IdRegWrite = 1;
        push("load_use", 32'h100, 32'h4, 32'h200, 4'h0, 5'd7, 6'b111010, 1);
        Flush = 1;

        step();
        Flush = 0;
        push("flush_bubble", 0, 0, 0, 4'h0, 0, 6'b000000, 0);

        step();
        Stall = 1; Flush = 1;
        IdRegData1 = 32'hF00D; IdRd = 5'd20; IdBranch = 1;
        push("after_flush_capture", 32'h10, 32'h20, 32'h20, 4'b0010, 5'd10, 6'b110000, 0);

        step();
        Stall = 0; Flush = 0; IdValid = 0;
        push("stall_flush_bubble", 0, 0, 0, 4'h0, 0, 6'b000000, 0);

        step();
        clear_id();
        IdValid = 1; IdRs1 = 5'd3; IdRs2 = 5'd4; IdRd = 5'd12;
        IdRegData1 = 32'h1234; IdRegData2 = 32'h5678; IdALUControl = 4'b1100; IdRegWrite = 1;
        push("invalid_bubble", 0, 0, 0, 4'h0, 0, 6'b000000, 0);

        step();
        Stall = 1;
        push("xor_capture", 32'h1234, 32'h5678, 32'h5678, 4'b1100, 5'd12, 6'b110000, 0);

        step();
        reset = 1;
        push("async_reset", 0, 0, 0, 4'h0, 0, 6'b000000, 0);

        step();
        reset = 0;
        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            bad++;
            total++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
